// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter:
// FSM state encoding, ALU group codes and datapath widths.
package alu_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int CODE_W = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ALU code bits [4:3] select one of these groups; bits [2:0] pick the op.
    typedef enum logic [1:0] {
        ARITH   = 2'b00,
        LOGIC   = 2'b01,
        SHIFT   = 2'b10,
        SETCOND = 2'b11
    } group_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/grant/completion bundle between two ALU requesters and the arbiter.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic  req0, req1;
    code_t code0, code1;
    data_t a0, b0, a1, b1;
    logic  gnt0, gnt1;
    logic  done0, done1;
    data_t result;
    logic  overflow;
    logic  busy;

    modport master (
        output req0, code0, a0, b0, req1, code1, a1, b1,
        input  gnt0, gnt1, done0, done1, result, overflow, busy
    );

    modport slave (
        input  req0, code0, a0, b0, req1, code1, a1, b1,
        output gnt0, gnt1, done0, done1, result, overflow, busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 16-bit ALU; v is the signed overflow of the arithmetic ops.
module alu_module
    import alu_arbiter_pkg::*;
(
    input  code_t code,
    input  data_t a,
    input  data_t b,
    output data_t y,
    output logic  v
);

    logic [3:0]          amt;
    logic [2*DATA_W-1:0] rot;
    logic                cond;

    always_comb begin
        y    = a;
        v    = 1'b0;
        amt  = b[3:0];
        rot  = '0;
        cond = 1'b0;
        case (group_t'(code[4:3]))
            ARITH: case (code[2:0])
                3'd0: begin y = a + b;       v = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]); end
                3'd1: begin y = a - b;       v = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]); end
                3'd2: begin y = a + 16'd1;   v = (a == 16'h7FFF); end
                3'd3: begin y = a - 16'd1;   v = (a == 16'h8000); end
                3'd4: begin y = 16'd0 - a;   v = (a == 16'h8000); end
                default: y = a;
            endcase
            LOGIC: case (code[2:0])
                3'd0: y = a & b;
                3'd1: y = a | b;
                3'd2: y = a ^ b;
                3'd3: y = ~(a & b);
                3'd4: y = ~(a | b);
                3'd5: y = ~(a ^ b);
                3'd6: y = ~a;
                default: y = b;
            endcase
            SHIFT: case (code[2:0])
                3'd0: y = a << amt;
                3'd1: y = a >> amt;
                3'd2: y = $signed(a) >>> amt;
                3'd3: begin rot = {a, a} << amt; y = rot[2*DATA_W-1:DATA_W]; end
                3'd4: begin rot = {a, a} >> amt; y = rot[DATA_W-1:0]; end
                default: y = a;
            endcase
            SETCOND: begin
                case (code[2:0])
                    3'd0: cond = (a == b);
                    3'd1: cond = (a != b);
                    3'd2: cond = ($signed(a) < $signed(b));
                    3'd3: cond = (a < b);
                    3'd4: cond = ($signed(a) >= $signed(b));
                    3'd5: cond = (a >= b);
                    default: cond = 1'b0;
                endcase
                y = {{(DATA_W-1){1'b0}}, cond};
            end
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters:
// grant in IDLE, evaluate in EXEC, signal completion in DONE.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_t state, state_next;
    logic   last_grant;
    logic   owner;
    logic   take;
    logic   pick;
    code_t  code_q;
    data_t  a_q, b_q;
    data_t  alu_y, result_q;
    logic   alu_v, overflow_q;

    alu_module u_alu (
        .code (code_q),
        .a    (a_q),
        .b    (b_q),
        .y    (alu_y),
        .v    (alu_v)
    );

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        take         = bus.req0 | bus.req1;
        pick         = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
        state_next   = state;
        bus.gnt0     = 1'b0;
        bus.gnt1     = 1'b0;
        bus.done0    = 1'b0;
        bus.done1    = 1'b0;
        bus.busy     = 1'b0;
        bus.result   = result_q;
        bus.overflow = overflow_q;
        case (state)
            S_IDLE: begin
                // Grants are combinational, so hold them off while reset is asserted.
                if (take && !rst) begin
                    bus.gnt0   = ~pick;
                    bus.gnt1   = pick;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.busy   = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                bus.busy   = 1'b1;
                bus.done0  = ~owner;
                bus.done1  = owner;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            code_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && take) begin
                owner  <= pick;
                code_q <= pick ? bus.code1 : bus.code0;
                a_q    <= pick ? bus.a1    : bus.a0;
                b_q    <= pick ? bus.b1    : bus.b0;
            end
            if (state == S_EXEC) begin
                result_q   <= alu_y;
                overflow_q <= (code_q[4:3] == ARITH) && alu_v;
            end
            if (state == S_DONE) begin
                last_grant <= owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic against an integer-arithmetic ALU model and round-robin history.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   last_model = 1;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_alu(input code_t code, input data_t a, input data_t b,
                                    output data_t y, output logic v);
        int sa, sb, ua, ub, n, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        n  = int'(b[3:0]);
        r  = ua;
        v  = 1'b0;
        case (code[4:3])
            2'b00: begin
                case (code[2:0])
                    3'd0: r = sa + sb;
                    3'd1: r = sa - sb;
                    3'd2: r = sa + 1;
                    3'd3: r = sa - 1;
                    3'd4: r = -sa;
                    default: r = sa;
                endcase
                v = (r > 32767) || (r < -32768);
            end
            2'b01: case (code[2:0])
                3'd0: r = ua & ub;
                3'd1: r = ua | ub;
                3'd2: r = ua ^ ub;
                3'd3: r = ~(ua & ub);
                3'd4: r = ~(ua | ub);
                3'd5: r = ~(ua ^ ub);
                3'd6: r = ~ua;
                default: r = ub;
            endcase
            2'b10: case (code[2:0])
                3'd0: r = ua << n;
                3'd1: r = ua >> n;
                3'd2: r = sa >>> n;
                3'd3: r = (ua << n) | (ua >> (16 - n));
                3'd4: r = (ua >> n) | (ua << (16 - n));
                default: r = ua;
            endcase
            default: case (code[2:0])
                3'd0: r = (ua == ub) ? 1 : 0;
                3'd1: r = (ua != ub) ? 1 : 0;
                3'd2: r = (sa < sb) ? 1 : 0;
                3'd3: r = (ua < ub) ? 1 : 0;
                3'd4: r = (sa >= sb) ? 1 : 0;
                3'd5: r = (ua >= ub) ? 1 : 0;
                default: r = 0;
            endcase
        endcase
        y = data_t'(r);
    endfunction

    function automatic data_t pick_data();
        case ($urandom_range(0, 3))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return data_t'($urandom);
        endcase
    endfunction

    // One request from a single requester; operands are scrambled right after the grant.
    task automatic run_op(input string name, input int who, input code_t code,
                          input data_t a, input data_t b, input data_t exp_y, input logic exp_v);
        int   waited;
        int   lat;
        logic g, d, d_other;
        if (who == 0) begin
            bus.code0 = code; bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
        end else begin
            bus.code1 = code; bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1;
        end
        #1;
        waited = 0;
        g = (who == 0) ? bus.gnt0 : bus.gnt1;
        while (g !== 1'b1 && waited < 5) begin
            step(); #1; waited++;
            g = (who == 0) ? bus.gnt0 : bus.gnt1;
        end
        tests++;
        if (g !== 1'b1 || waited != 0) begin
            fails++;
            $display("FAIL %s_gnt: granted=%b after %0d cycles, want granted after 0", name, g, waited);
        end
        if (g !== 1'b1) begin
            bus.req0 = 1'b0; bus.req1 = 1'b0; step();
            return;
        end
        step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (who == 0) begin
            bus.code0 = code_t'($urandom); bus.a0 = 16'hFFFF; bus.b0 = data_t'($urandom);
        end else begin
            bus.code1 = code_t'($urandom); bus.a1 = 16'hFFFF; bus.b1 = data_t'($urandom);
        end
        lat = 1;
        d = (who == 0) ? bus.done0 : bus.done1;
        while (d !== 1'b1 && lat < 6) begin
            step(); lat++;
            d = (who == 0) ? bus.done0 : bus.done1;
        end
        tests++;
        if (d !== 1'b1 || lat != 2) begin
            fails++;
            $display("FAIL %s_latency: done=%b after %0d cycles, want done after 2", name, d, lat);
        end
        if (d === 1'b1) begin
            d_other = (who == 0) ? bus.done1 : bus.done0;
            tests++;
            if (bus.result !== exp_y) begin
                fails++;
                $display("FAIL %s_result: got %h want %h", name, bus.result, exp_y);
            end
            tests++;
            if (bus.overflow !== exp_v) begin
                fails++;
                $display("FAIL %s_overflow: got %b want %b", name, bus.overflow, exp_v);
            end
            tests++;
            if (d_other !== 1'b0) begin
                fails++;
                $display("FAIL %s_other_done: got %b want 0", name, d_other);
            end
        end
        step();
        last_model = who;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.code0 = '0; bus.a0 = '0; bus.b0 = '0;
        bus.code1 = '0; bus.a1 = '0; bus.b1 = '0;
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.overflow} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: gnt0/gnt1/done0/done1/busy/ovf=%b want 000000",
                     {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.overflow});
        end
        tests++;
        if (bus.result !== 16'h0000) begin
            fails++;
            $display("FAIL reset_result: got %h want 0000", bus.result);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        rst = 1'b0;
        step();
        last_model = 1;
    endtask

    task automatic test_single();
        run_op("single_add", 0, 5'b00000, 16'h0003, 16'h0004, 16'h0007, 1'b0);
        #1;
        tests++;
        if (bus.result !== 16'h0007 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL single_hold: result=%h busy=%b want 0007 and 0", bus.result, bus.busy);
        end
    endtask

    task automatic test_overflow();
        data_t y;
        logic  v;
        run_op("ovf_add", 1, 5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
        ref_alu(5'b01000, 16'h7FFF, 16'h0001, y, v);
        run_op("ovf_logic", 1, 5'b01000, 16'h7FFF, 16'h0001, y, 1'b0);
        run_op("ovf_sub", 0, 5'b00001, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
    endtask

    task automatic test_isolation();
        run_op("isolation", 0, 5'b00000, 16'h1234, 16'h0001, 16'h1235, 1'b0);
    endtask

    // Requester 0 held high alone: re-granted at every IDLE, i.e. every third cycle.
    task automatic test_back_to_back();
        int gc[$];
        bit stray;
        stray = 1'b0;
        bus.code0 = 5'b00010; bus.a0 = 16'h0010; bus.b0 = 16'h0000;
        bus.req0 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (bus.gnt0 === 1'b1) gc.push_back(c);
            if (bus.gnt1 !== 1'b0) stray = 1'b1;
            step();
        end
        bus.req0 = 1'b0;
        tests++;
        if (gc.size() != 3 || stray) begin
            fails++;
            $display("FAIL b2b_count: %0d grants (stray gnt1=%b) want 3", gc.size(), stray);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (gc[i] != 3 * i) begin
                    fails++;
                    $display("FAIL b2b_cycle%0d: got %0d want %0d", i, gc[i], 3 * i);
                end
            end
        end
        last_model = 0;
    endtask

    task automatic test_contention();
        int    gw[$], gcyc[$], dw[$], dcyc[$];
        data_t dres[$];
        data_t ey;
        logic  ev;
        int    exp_who;
        bit    overlap;
        overlap = 1'b0;
        rst = 1'b1; step(); rst = 1'b0; step();
        last_model = 1;
        bus.code0 = 5'b00000; bus.a0 = 16'd10;  bus.b0 = 16'd20;
        bus.code1 = 5'b00001; bus.a1 = 16'd100; bus.b1 = 16'd1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) overlap = 1'b1;
            if (bus.done0 === 1'b1 && bus.done1 === 1'b1) overlap = 1'b1;
            if (bus.gnt0 === 1'b1) begin gw.push_back(0); gcyc.push_back(c); end
            if (bus.gnt1 === 1'b1) begin gw.push_back(1); gcyc.push_back(c); end
            if (bus.done0 === 1'b1) begin dw.push_back(0); dcyc.push_back(c); dres.push_back(bus.result); end
            if (bus.done1 === 1'b1) begin dw.push_back(1); dcyc.push_back(c); dres.push_back(bus.result); end
            step();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tests++;
        if (overlap) begin
            fails++;
            $display("FAIL contention_onehot: simultaneous gnt or done seen, want at most one");
        end
        tests++;
        if (gw.size() != 4 || dw.size() != 4) begin
            fails++;
            $display("FAIL contention_count: %0d grants %0d dones want 4 and 4", gw.size(), dw.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_who = 1 - last_model;
                last_model = exp_who;
                if (exp_who == 0) ref_alu(5'b00000, 16'd10, 16'd20, ey, ev);
                else              ref_alu(5'b00001, 16'd100, 16'd1, ey, ev);
                tests++;
                if (gw[i] != exp_who || gcyc[i] != 3 * i) begin
                    fails++;
                    $display("FAIL contention_gnt%0d: requester %0d at cycle %0d want %0d at %0d",
                             i, gw[i], gcyc[i], exp_who, 3 * i);
                end
                tests++;
                if (dw[i] != exp_who || dcyc[i] != 3 * i + 2 || dres[i] !== ey) begin
                    fails++;
                    $display("FAIL contention_done%0d: requester %0d cycle %0d result %h want %0d %0d %h",
                             i, dw[i], dcyc[i], dres[i], exp_who, 3 * i + 2, ey);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen_done;
        seen_done = 1'b0;
        bus.code0 = 5'b00000; bus.a0 = 16'd5; bus.b0 = 16'd6;
        bus.req0 = 1'b1;
        #1;
        tests++;
        if (bus.gnt0 !== 1'b1) begin
            fails++;
            $display("FAIL midrst_gnt: got %b want 1", bus.gnt0);
        end
        step();
        bus.req0 = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.result !== 16'h0000 || bus.overflow !== 1'b0) begin
            fails++;
            $display("FAIL midrst_state: busy=%b result=%h ovf=%b want 0 0000 0",
                     bus.busy, bus.result, bus.overflow);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.done0 !== 1'b0 || bus.done1 !== 1'b0) seen_done = 1'b1;
            step();
        end
        tests++;
        if (seen_done) begin
            fails++;
            $display("FAIL midrst_nodone: done pulse seen after abort, want none");
        end
        last_model = 1;
        run_op("midrst_next", 0, 5'b00000, 16'd5, 16'd6, 16'd11, 1'b0);
    endtask

    task automatic test_random();
        int    pat, exp_who;
        code_t c0, c1;
        data_t x0, y0, x1, y1, ey;
        logic  ev;
        for (int i = 0; i < 60; i++) begin
            pat = $urandom_range(1, 3);
            c0 = code_t'($urandom); x0 = pick_data(); y0 = pick_data();
            c1 = code_t'($urandom); x1 = pick_data(); y1 = pick_data();
            bus.code0 = c0; bus.a0 = x0; bus.b0 = y0;
            bus.code1 = c1; bus.a1 = x1; bus.b1 = y1;
            bus.req0 = (pat != 2);
            bus.req1 = (pat != 1);
            exp_who = (pat == 3) ? 1 - last_model : ((pat == 1) ? 0 : 1);
            #1;
            tests++;
            if ({bus.gnt1, bus.gnt0} !== ((exp_who == 1) ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL rand%0d_gnt: gnt1,gnt0=%b want requester %0d", i, {bus.gnt1, bus.gnt0}, exp_who);
            end
            step();
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            bus.code0 = code_t'($urandom); bus.a0 = data_t'($urandom); bus.b0 = data_t'($urandom);
            bus.code1 = code_t'($urandom); bus.a1 = data_t'($urandom); bus.b1 = data_t'($urandom);
            step();
            if (exp_who == 0) ref_alu(c0, x0, y0, ey, ev);
            else              ref_alu(c1, x1, y1, ey, ev);
            tests++;
            if ({bus.done1, bus.done0} !== ((exp_who == 1) ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL rand%0d_done: done1,done0=%b want requester %0d", i, {bus.done1, bus.done0}, exp_who);
            end
            tests++;
            if (bus.result !== ey || bus.overflow !== ev) begin
                fails++;
                $display("FAIL rand%0d_result: code=%b got %h/%b want %h/%b", i,
                         (exp_who == 1) ? c1 : c0, bus.result, bus.overflow, ey, ev);
            end
            step();
            #1;
            tests++;
            if ({bus.gnt1, bus.gnt0, bus.busy} !== 3'b000) begin
                fails++;
                $display("FAIL rand%0d_idle: gnt1,gnt0,busy=%b want 000", i, {bus.gnt1, bus.gnt0, bus.busy});
            end
            last_model = exp_who;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_isolation();
        test_back_to_back();
        test_contention();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 16 bits and ALU code width at 5 bits.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 operation request, level, held until gnt0.
REQ-005 code0  input  5  requester 0 ALU code; bits [4:3] select group, [2:0] select op.
REQ-006 a0, b0  input  16 each  requester 0 operands.
REQ-007 req1, code1, a1, b1  input  1/5/16/16  requester 1 equivalents.
REQ-008 gnt0, gnt1  output  1 each  one-cycle accept pulse; operands sampled on this cycle.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse; result valid on this cycle.
REQ-010 result  output  16  registered ALU result of the last completed operation.
REQ-011 overflow  output  1  registered overflow of the last completed operation.
REQ-012 busy  output  1  high in EXEC and DONE states.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-014 IDLE: with no request, stay in IDLE; otherwise grant one requester, latch its code/a/b, pulse its gnt, and go to EXEC.
REQ-015 Arbitration SHALL be round-robin: with both req high, grant the requester not granted last; with one req high, grant it regardless of history.
REQ-016 EXEC: the ALU SHALL evaluate the latched operands combinationally; result and overflow registers SHALL load at the end of EXEC; next state DONE.
REQ-017 DONE: pulse done of the granted requester, update last-grant to that requester, and return to IDLE.
REQ-018 Latency SHALL be 2 cycles from gnt to done; throughput is one operation per 3 cycles.
REQ-019 A requester holding req high after its gnt SHALL be treated as a new request at the next IDLE.
REQ-020 Input changes after gnt SHALL NOT affect the operation in flight.
REQ-021 overflow SHALL equal ALU vout when latched code[4:3]==2'b00, else 0.
REQ-022 result and overflow SHALL hold their value between done pulses.
REQ-023 At most one of gnt0/gnt1, and at most one of done0/done1, SHALL be high in any cycle.
REQ-024 A requester dropping req before grant SHALL NOT be granted.

Reset
REQ-025 Reset SHALL force IDLE; gnt0/1, done0/1, busy, overflow = 0; result = 16'h0000.
REQ-026 Reset SHALL set last-grant to requester 1, so requester 0 wins the first contention.
REQ-027 Reset in EXEC or DONE SHALL abort the operation with no done pulse.

Structure
REQ-028 A shared package SHALL hold state encoding, ALU group constants (ARITH=2'b00, LOGIC=2'b01, SHIFT=2'b10, SETCOND=2'b11) and data/code width constants.
REQ-029 The block SHALL instantiate exactly one alu_module as its only sub-module, fed from the latched operand registers.

Verification
REQ-030 Single request: req0, code 5'b00000 (add), a0=16'h0003, b0=16'h0004 -> gnt0 at cycle 0, done0 at cycle 2, result=16'h0007, overflow=0.
REQ-031 Overflow: req1, code 5'b00000, a1=16'h7FFF, b1=16'h0001 -> done1, result=16'h8000, overflow=1; same operands with code 5'b01000 -> overflow=0.
REQ-032 Contention after reset: req0 and req1 held high -> grant order 0,1,0,1; gnt spacing 3 cycles; done matches each grant.
REQ-033 Operand isolation: change a0 to 16'hFFFF the cycle after gnt0 -> result computed from the original a0.
REQ-034 Reset mid-op: assert rst in EXEC -> no done pulse, result=16'h0000, busy=0; next req0 is granted normally.
